nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand width in bits; legal values are multiples of 4 in the range 4..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 The block SHALL have port sub, input, 1 bit: subtract request, captured with the operands; only honoured when SUB_EN is defined.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result, held stable until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the most significant nibble.
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement overflow of the final nibble.

Function
REQ-013 The block SHALL add one 4-bit slice per cycle using an internal carry-lookahead nibble: g=a&b, p=a|b, ci+1=gi|(pi&ci), s=a^b^ci.
REQ-014 The carry between slices SHALL be registered; carry-in to nibble 0 SHALL be 0 for add.
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-016 IDLE->ADD SHALL occur when start=1: capture a, b, and sub, clear the nibble index and the sum register, and assert busy.
REQ-017 In ADD, each cycle SHALL write nibble[idx] of sum, register the carry, and increment idx.
REQ-018 After nibble WIDTH/4-1 is written, ADD->DONE SHALL occur, latching cout and ovf (carry-in XOR carry-out of the top bit).
REQ-019 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-020 Latency SHALL be fixed: start accepted at edge N; done high in cycle N+WIDTH/4+1.
REQ-021 start SHALL be ignored while busy=1 or done=1; captured operands SHALL NOT change mid-operation.
REQ-022 start asserted in the same cycle done is high SHALL be ignored; start asserted the following cycle (in IDLE) SHALL be accepted.
REQ-023 While an operation is in progress, sum SHALL expose partially written nibbles, and only the value present when done=1 SHALL be treated as valid.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; the carry out of the top nibble SHALL go only to cout.

Reset
REQ-025 When rst=1 at a clk edge, the block SHALL enter IDLE with busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry register=0.
REQ-026 Reset SHALL take priority over start and SHALL abort any operation in progress with no done pulse.
REQ-027 The first start SHALL be accepted at the first edge with rst=0.

Configuration
REQ-028 Macro NIBBLE_SERIAL_ADDER_SUB_EN, when defined, SHALL make sub=1 invert the captured b and force carry-in to nibble 0 to 1, computing a-b; cout=1 then means no borrow.
REQ-029 Without NIBBLE_SERIAL_ADDER_SUB_EN, the sub input SHALL be ignored, and the block SHALL always add.

Verification (WIDTH=16)
REQ-030 The bench SHALL drive a=0x1234, b=0x4321, start for one cycle; required response: busy for 4 ADD cycles, done at N+5, sum=0x5555, cout=0, ovf=0.
REQ-031 The bench SHALL drive a=0xFFFF, b=0x0001; required response: sum=0x0000, cout=1, ovf=0, with the carry rippling through all four nibbles.
REQ-032 The bench SHALL drive a=0x7FFF, b=0x0001; required response: sum=0x8000, cout=0, ovf=1.
REQ-033 The bench SHALL pulse start again during ADD with different operands; required response: ignored, first result unchanged, exactly one done pulse.
REQ-034 The bench SHALL assert rst in the second ADD cycle; required response: next cycle busy=0, sum=0, no done, and a fresh start then completes normally.
REQ-035 With SUB_EN defined, the bench SHALL drive a=0x0005, b=0x0007, sub=1; required response: sum=0xFFFE, cout=0. Without SUB_EN, the same stimulus SHALL give sum=0x000C.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial adder with carry-lookahead slice (optional subtract: NIBBLE_SERIAL_ADDER_SUB_EN)

// One 4-bit carry-lookahead slice; c3 is the carry into bit 3 (for overflow).
module nibble_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and fully expanded lookahead carries
  always_comb begin
    g    = a & b;
    p    = a | b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = a ^ b ^ c[3:0];
    c3   = c[3];
    co   = c[4];
  end

endmodule

// Top: captures operands on start, then produces one result nibble per cycle.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  logic             carry_q;

  logic [WIDTH-1:0] b_in;
  logic             cin0;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             c3_nib;
  logic             co_nib;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1: invert B at capture and seed the carry chain with 1
  assign b_in = sub ? ~b : b;
  assign cin0 = sub;
`else
  // Add-only build: sub has no effect
  wire unused_sub = sub;
  assign b_in = b;
  assign cin0 = 1'b0;
`endif

  assign a_nib = a_q[{idx, 2'b00} +: 4];
  assign b_nib = b_q[{idx, 2'b00} +: 4];

  nibble_cla u_cla (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .c3 (c3_nib),
    .co (co_nib)
  );

  // Control FSM with registered status outputs and the nibble datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= cin0;
            idx     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          sum[{idx, 2'b00} +: 4] <= s_nib;
          carry_q <= co_nib;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Top carry only reaches cout; the sum wraps modulo 2^WIDTH
            cout  <= co_nib;
            ovf   <= c3_nib ^ co_nib;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed bench for nibble_serial_adder (WIDTH=16)
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vs;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation at a negedge in IDLE; done is expected 5 negedges later
  task automatic run_vec(input string name, input vec_t v);
    a = v.va; b = v.vb; sub = v.vs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_k1"}, busy, 1);
    for (int k = 2; k <= 4; k++) @(negedge clk);
    check({name, " busy_k4"}, {busy, done}, 2'b10);
    @(negedge clk);
    check({name, " done_k5"}, {busy, done}, 2'b01);
    check({name, " sum"}, sum, v.es);
    check({name, " cout"}, cout, v.ec);
    check({name, " ovf"}, ovf, v.eo);
    @(negedge clk);
    check({name, " done_off"}, done, 0);
    check({name, " sum_hold"}, sum, v.es);
  endtask

  initial begin
    int   done_cnt;
    vec_t v;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    vecs[6] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{16'h9000, 16'h1000, 1'b1, 16'h8000, 1'b1, 1'b0};
`else
    vecs[6] = '{16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0};
    vecs[7] = '{16'h9000, 16'h1000, 1'b1, 16'hA000, 1'b0, 1'b0};
`endif

    // Reset with start held high: start must not be taken until rst drops
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002; sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 16'h0000);
    check("reset_cout_ovf", {cout, ovf}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("first_start_accepted", busy, 1);
    for (int k = 2; k <= 5; k++) @(negedge clk);
    check("first_done", done, 1);
    check("first_sum", sum, 16'h0003);
    @(negedge clk);

    // Partial-nibble visibility while the first vector adds
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("partial_k1", sum, 16'h0000);
    @(negedge clk);
    check("partial_k2", sum, 16'h0005);
    @(negedge clk);
    check("partial_k3", sum, 16'h0055);
    @(negedge clk);
    check("partial_k4", sum, 16'h0555);
    @(negedge clk);
    check("partial_done", {done, sum}, {1'b1, 16'h5555});
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      run_vec($sformatf("vec%0d", i), v);
    end

    // Start pulsed mid-operation must be ignored; exactly one done pulse
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("midstart_sum", sum, 16'h5555);
      end
    end
    check("midstart_one_done", done_cnt, 1);
    check("midstart_idle", busy, 0);

    // Start held during the done cycle: ignored there, accepted the cycle after
    a = 16'h0100; b = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 5; k++) @(negedge clk);
    check("donestart_done", done, 1);
    a = 16'h0F0F; b = 16'h0101; start = 1'b1;
    @(negedge clk);
    check("donestart_ignored", {busy, done}, 2'b00);
    check("donestart_sum_hold", sum, 16'h0300);
    @(negedge clk);
    start = 1'b0;
    check("donestart_accepted", busy, 1);
    for (int k = 2; k <= 5; k++) @(negedge clk);
    check("donestart_second_done", done, 1);
    check("donestart_second_sum", sum, 16'h1010);
    @(negedge clk);

    // Reset during the second ADD cycle aborts without a done pulse
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 16'h0000);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);
    v = vecs[0];
    run_vec("after_abort", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
